// File: rtl/riscv_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, its reset value,
// and the table-maintenance FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = CTR_WNT;

    typedef enum logic [0:0] {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_e;

    function automatic logic ctr_is_taken(input ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step: increment on taken, decrement on
// not-taken, clamped at ST and SNT.
module bp_sat_counter
    import riscv_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    // next counter value
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
            default: ctr_o = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a flush-driven table clear FSM.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the index.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pred_valid_i,
    input  logic [63:0]                pred_pc_i,
    output logic                       pred_valid_o,
    output logic                       pred_taken_o,
    output logic [$clog2(ENTRIES)-1:0] pred_idx_o,
    input  logic                       upd_valid_i,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
    input  logic                       upd_taken_i,
    input  logic                       flush_i,
    output logic                       ready_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_state_e        state_r;
    bp_state_e        state_nxt_s;
    logic [IDX_W-1:0] clr_ptr_r;
    logic [IDX_W-1:0] clr_ptr_nxt_s;
    ctr_e             table_r [ENTRIES];
    ctr_e             upd_ctr_s;
    logic [IDX_W-1:0] lkp_idx_s;
    logic             idle_s;
    logic             lkp_en_s;
    logic             upd_en_s;
    logic             clr_en_s;
    logic             unused_pc_s;

    assign unused_pc_s = ^{pred_pc_i[63:IDX_W+2], pred_pc_i[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_r;

    assign lkp_idx_s = pred_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_r);

    // global history: cleared on flush, shifted by every accepted update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (flush_i) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (upd_en_s) begin
            ghr_r <= {ghr_r[GHR_BITS-2:0], upd_taken_i};
        end
    end
`else
    assign lkp_idx_s = pred_pc_i[IDX_W+1:2];
`endif

    assign idle_s   = (state_r == BP_IDLE);
    assign lkp_en_s = idle_s && pred_valid_i && !flush_i;
    assign upd_en_s = idle_s && upd_valid_i && !flush_i;
    assign clr_en_s = (state_r == BP_CLEAR) && !flush_i;
    assign ready_o  = idle_s;

    bp_sat_counter u_sat_counter (
        .ctr_i   (table_r[upd_idx_i]),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_ctr_s)
    );

    // clear FSM next state; a flush in CLEAR restarts the sweep from entry 0
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            BP_IDLE: begin
                if (flush_i) begin
                    state_nxt_s   = BP_CLEAR;
                    clr_ptr_nxt_s = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s   = BP_IDLE;
                end
            end
            BP_CLEAR: begin
                if (flush_i) begin
                    state_nxt_s   = BP_CLEAR;
                    clr_ptr_nxt_s = {IDX_W{1'b0}};
                end else if (clr_ptr_r == IDX_W'(ENTRIES - 1)) begin
                    state_nxt_s   = BP_IDLE;
                    clr_ptr_nxt_s = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s   = BP_CLEAR;
                    clr_ptr_nxt_s = clr_ptr_r + IDX_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s   = BP_IDLE;
                clr_ptr_nxt_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // FSM state and clear pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= BP_IDLE;
            clr_ptr_r <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
        end
    end

    // counter table; nonblocking writes give same-edge lookups the old value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CTR_RESET;
            end
        end else if (clr_en_s) begin
            table_r[clr_ptr_r] <= CTR_RESET;
        end else if (upd_en_s) begin
            table_r[upd_idx_i] <= upd_ctr_s;
        end
    end

    // registered lookup result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_idx_o   <= {IDX_W{1'b0}};
        end else begin
            pred_valid_o <= lkp_en_s;
            if (lkp_en_s) begin
                pred_taken_o <= ctr_is_taken(table_r[lkp_idx_s]);
                pred_idx_o   <= lkp_idx_s;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 64 entries);
// the gshare vector runs only when BP_GSHARE_EN is defined.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pred_valid_i;
    logic [63:0] pred_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [5:0]  pred_idx_o;
    logic        upd_valid_i;
    logic [5:0]  upd_idx_i;
    logic        upd_taken_i;
    logic        flush_i;
    logic        ready_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [5:0]  ghr_m = 6'd0;

    branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(6)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pred_valid_i (pred_valid_i),
        .pred_pc_i    (pred_pc_i),
        .pred_valid_o (pred_valid_o),
        .pred_taken_o (pred_taken_o),
        .pred_idx_o   (pred_idx_o),
        .upd_valid_i  (upd_valid_i),
        .upd_idx_i    (upd_idx_i),
        .upd_taken_i  (upd_taken_i),
        .flush_i      (flush_i),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // PC that lands on table entry idx, with junk in the bits the index ignores
    function automatic logic [63:0] pc_for(input logic [5:0] idx);
`ifdef BP_GSHARE_EN
        return {32'hDEAD_0000, 24'd0, idx ^ ghr_m, 2'b10};
`else
        return {32'hDEAD_0000, 24'd0, idx, 2'b10};
`endif
    endfunction

    function automatic int count_not_wnt();
        int   n;
        logic [1:0] v;
        n = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            v = dut.table_r[i];
            if (v !== 2'b01) n++;
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [5:0] idx, input logic taken);
        upd_valid_i = 1'b1;
        upd_idx_i   = idx;
        upd_taken_i = taken;
        step();
        upd_valid_i = 1'b0;
        ghr_m       = {ghr_m[4:0], taken};
    endtask

    task automatic do_predict(input string tag, input logic [5:0] idx, input logic exp_taken);
        pred_valid_i = 1'b1;
        pred_pc_i    = pc_for(idx);
        step();
        pred_valid_i = 1'b0;
        check_eq({tag, "_valid"}, 32'(pred_valid_o), 32'd1);
        check_eq({tag, "_idx"},   32'(pred_idx_o),   32'(idx));
        check_eq({tag, "_taken"}, 32'(pred_taken_o), 32'(exp_taken));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int low_cnt;
        int guard;
        rst_i = 1'b1; pred_valid_i = 1'b0; pred_pc_i = 64'd0;
        upd_valid_i = 1'b0; upd_idx_i = 6'd0; upd_taken_i = 1'b0; flush_i = 1'b0;
        step(); step();
        rst_i = 1'b0;

        check_eq("rst_valid", 32'(pred_valid_o), 32'd0);
        check_eq("rst_taken", 32'(pred_taken_o), 32'd0);
        check_eq("rst_idx",   32'(pred_idx_o),   32'd0);
        check_eq("rst_ready", 32'(ready_o),      32'd1);
        check_eq("rst_table", 32'(count_not_wnt()), 32'd0);

        // first lookup after reset: pc 0x1000 -> entry 0, weakly not-taken
        pred_valid_i = 1'b1; pred_pc_i = 64'h1000;
        step();
        pred_valid_i = 1'b0;
        check_eq("p1000_valid", 32'(pred_valid_o), 32'd1);
        check_eq("p1000_taken", 32'(pred_taken_o), 32'd0);
        check_eq("p1000_idx",   32'(pred_idx_o),   32'd0);
        step();
        check_eq("p1000_oneshot", 32'(pred_valid_o), 32'd0);

        // saturation at ST
        do_update(6'd0, 1'b1);
        do_update(6'd0, 1'b1);
        check_eq("sat_st_two", 32'(dut.table_r[0]), 32'd3);
        do_update(6'd0, 1'b1);
        do_predict("sat_st", 6'd0, 1'b1);
        do_update(6'd0, 1'b0);
        do_predict("st_dec", 6'd0, 1'b1);
        do_update(6'd0, 1'b0);
        do_predict("wt_dec", 6'd0, 1'b0);

        // saturation at SNT
        do_update(6'd1, 1'b0);
        do_update(6'd1, 1'b0);
        do_update(6'd1, 1'b1);
        do_predict("sat_snt", 6'd1, 1'b0);
        do_update(6'd1, 1'b1);
        do_predict("snt_inc", 6'd1, 1'b1);

        // same-edge predict and update: lookup sees the old counter
        pred_valid_i = 1'b1; pred_pc_i = pc_for(6'd2);
        upd_valid_i = 1'b1; upd_idx_i = 6'd2; upd_taken_i = 1'b1;
        step();
        pred_valid_i = 1'b0; upd_valid_i = 1'b0;
        ghr_m = {ghr_m[4:0], 1'b1};
        check_eq("rbw_valid", 32'(pred_valid_o), 32'd1);
        check_eq("rbw_taken", 32'(pred_taken_o), 32'd0);
        do_predict("rbw_after", 6'd2, 1'b1);

        // flush with a colliding update and lookup, then count CLEAR cycles
        do_update(6'd3, 1'b1);
        do_update(6'd3, 1'b1);
        flush_i = 1'b1;
        upd_valid_i = 1'b1; upd_idx_i = 6'd5; upd_taken_i = 1'b1;
        pred_valid_i = 1'b1; pred_pc_i = pc_for(6'd3);
        step();
        flush_i = 1'b0; upd_valid_i = 1'b0; pred_valid_i = 1'b0;
        ghr_m = 6'd0;
        check_eq("flush_ready", 32'(ready_o), 32'd0);
        check_eq("flush_pvalid", 32'(pred_valid_o), 32'd0);
        low_cnt = 1;
        guard = 0;
        while (ready_o == 1'b0 && guard < 200) begin
            if (guard == 10) begin
                upd_valid_i = 1'b1; upd_idx_i = 6'd2; upd_taken_i = 1'b1;
                pred_valid_i = 1'b1; pred_pc_i = pc_for(6'd2);
            end
            step();
            upd_valid_i = 1'b0; pred_valid_i = 1'b0;
            if (guard == 10) check_eq("clear_pvalid", 32'(pred_valid_o), 32'd0);
            guard++;
            if (ready_o == 1'b0) low_cnt++;
        end
        check_eq("clear_cycles", 32'(low_cnt), 32'd64);
        check_eq("clear_table", 32'(count_not_wnt()), 32'd0);
        do_predict("post_clear", 6'd3, 1'b0);

`ifdef BP_GSHARE_EN
        do_update(6'd10, 1'b1);
        do_update(6'd11, 1'b1);
        do_update(6'd12, 1'b0);
        check_eq("ghr_value", 32'(dut.ghr_r), 32'h06);
        pred_valid_i = 1'b1; pred_pc_i = 64'h1000;
        step();
        pred_valid_i = 1'b0;
        check_eq("gshare_idx", 32'(pred_idx_o), 32'h06);
`endif

        // reset arriving in the middle of a clear sweep
        do_update(6'd7, 1'b1);
        do_update(6'd7, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check_eq("mid_ptr", 32'(dut.clr_ptr_r), 32'd20);
        check_eq("mid_ready", 32'(ready_o), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_ready", 32'(ready_o), 32'd1);
        check_eq("async_pvalid", 32'(pred_valid_o), 32'd0);
        check_eq("async_table", 32'(count_not_wnt()), 32'd0);
        step();
        rst_i = 1'b0;
        ghr_m = 6'd0;
        do_predict("post_rst", 6'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
